// File: rtl/ks_pkg.sv
// Shared types and helpers for the sequential wide Kogge-Stone adder.
//   KS_WORD_W  : default word width handled by the prefix slice per cycle
//   ks_state_e : control FSM states
//   ks_idx_w() : width of the word-index register for a given word count
package ks_pkg;

    parameter int unsigned KS_WORD_W = 32;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } ks_state_e;

    // A single-word build still needs a 1-bit index register.
    function automatic int unsigned ks_idx_w(input int unsigned words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/ks_prefix_slice.sv
// W-bit Kogge-Stone adder slice, purely combinational.
// Ports:
//   a, b  : W-bit addends
//   cin   : carry into bit 0
//   sum   : W-bit sum
//   cout  : carry out of bit W-1
module ks_prefix_slice #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    localparam int Wi     = int'(W);
    localparam int Stages = $clog2(W);

    logic [W-1:0] prop;
    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W-1:0] g_n;
    logic [W-1:0] p_n;
    logic [W:0]   carry;

    assign prop = a ^ b;

    always_comb begin
        g     = a & b;
        p     = a ^ b;
        g_n   = '0;
        p_n   = '0;
        carry = '0;
        // log2(W) prefix stages, span doubling each stage.
        for (int k = 0; k < Stages; k++) begin
            g_n = g;
            p_n = p;
            for (int i = (1 << k); i < Wi; i++) begin
                g_n[i] = g[i] | (p[i] & g[i - (1 << k)]);
                p_n[i] = p[i] & p[i - (1 << k)];
            end
            g = g_n;
            p = p_n;
        end
        // Group (G,P) over bits [i:0] folds cin in as a generate below bit 0.
        carry[0] = cin;
        for (int i = 0; i < Wi; i++) begin
            carry[i + 1] = g[i] | (p[i] & cin);
        end
    end

    assign sum  = prop ^ carry[W-1:0];
    assign cout = carry[W];

endmodule

// File: rtl/ks_wide_add_seq.sv
// Multi-cycle W*WORDS-bit adder. One operand pair is accepted over a valid/ready
// handshake, then added one W-bit word per cycle (LSW first) through a single
// Kogge-Stone slice with the carry chained through a register.
// Optional feature macro: KS_WIDE_SUB_EN adds in_sub (A-B when latched high).
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid/in_ready   : operand handshake; in_a, in_b, in_cin (and in_sub)
//   out_valid/out_ready : result handshake; out_sum, out_cout, out_ovf
module ks_wide_add_seq
    import ks_pkg::*;
#(
    parameter int unsigned W     = KS_WORD_W,
    parameter int unsigned WORDS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W*WORDS-1:0] in_a,
    input  logic [W*WORDS-1:0] in_b,
    input  logic               in_cin,
`ifdef KS_WIDE_SUB_EN
    input  logic               in_sub,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W*WORDS-1:0] out_sum,
    output logic               out_cout,
    output logic               out_ovf
);

    localparam int unsigned    IdxW    = ks_idx_w(WORDS);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(WORDS - 1);

    ks_state_e                  state_q, state_d;
    logic [IdxW-1:0]            idx_q, idx_d;
    logic                       carry_q, carry_d;
    logic [WORDS-1:0][W-1:0]    a_q, a_d;
    logic [WORDS-1:0][W-1:0]    b_q, b_d;
    logic [WORDS-1:0][W-1:0]    sum_q, sum_d;
    logic                       cout_q, cout_d;
    logic                       ovf_q, ovf_d;

    logic                       accept;
    logic                       last_word;
    logic                       sub_eff;
    logic [W-1:0]               a_word;
    logic [W-1:0]               b_word;
    logic [W-1:0]               slice_sum;
    logic                       slice_cout;

`ifdef KS_WIDE_SUB_EN
    assign sub_eff = in_sub;
`else
    assign sub_eff = 1'b0;
`endif

    assign accept    = in_valid & in_ready;
    assign last_word = (idx_q == LastIdx);

    // Word select by comparison keeps the WORDS=1 build free of index-width issues.
    always_comb begin
        a_word = a_q[0];
        b_word = b_q[0];
        for (int k = 0; k < int'(WORDS); k++) begin
            if (idx_q == IdxW'(k)) begin
                a_word = a_q[k];
                b_word = b_q[k];
            end
        end
    end

    ks_prefix_slice #(
        .W (W)
    ) u_slice (
        .a    (a_word),
        .b    (b_word),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (accept)    state_d = StRun;
            StRun:  if (last_word) state_d = StDone;
            StDone: if (out_ready) state_d = StIdle;
            default:               state_d = StIdle;
        endcase
    end

    // FSM outputs.
    always_comb begin
        in_ready  = rst_n & (state_q == StIdle);
        out_valid = (state_q == StDone);
    end

    // Datapath next state.
    always_comb begin
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        if (accept) begin
            a_d     = in_a;
            // Subtract stores ~B and a forced carry-in so RUN is a plain add.
            b_d     = sub_eff ? ~in_b : in_b;
            carry_d = sub_eff ? 1'b1 : in_cin;
            idx_d   = '0;
        end else if (state_q == StRun) begin
            for (int k = 0; k < int'(WORDS); k++) begin
                if (idx_q == IdxW'(k)) begin
                    sum_d[k] = slice_sum;
                end
            end
            carry_d = slice_cout;
            if (last_word) begin
                idx_d  = '0;
                cout_d = slice_cout;
                ovf_d  = (a_word[W-1] == b_word[W-1]) & (slice_sum[W-1] != a_word[W-1]);
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out_sum  = sum_q;
    assign out_cout = cout_q;
    assign out_ovf  = ovf_q;

endmodule
